// File: rtl/rtl_str_unit.sv
// Registered two-operand gate bank built from per-bit gate primitives (NOT/NOR/OR/AND/NAND/XOR/XNOR).
// Optional build macro RTL_STR_IN_REG_EN adds a reset-to-zero input register stage (latency 2 instead of 1).
module rtl_str_unit #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] not_g,
    output logic [WIDTH-1:0] nor_g,
    output logic [WIDTH-1:0] or_g,
    output logic [WIDTH-1:0] and_g,
    output logic [WIDTH-1:0] nand_g,
    output logic [WIDTH-1:0] xor_g,
    output logic [WIDTH-1:0] xnor_g,
    output logic             out_valid
);

    logic [WIDTH-1:0] g_a;
    logic [WIDTH-1:0] g_b;
    logic             g_vld;

`ifdef RTL_STR_IN_REG_EN
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             vld_q;

    // Input stage; a reset here also drops any vector already sampled.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            vld_q <= 1'b0;
        end else begin
            a_q   <= a;
            b_q   <= b;
            vld_q <= in_valid;
        end
    end

    assign g_a   = a_q;
    assign g_b   = b_q;
    assign g_vld = vld_q;
`else
    assign g_a   = a;
    assign g_b   = b;
    assign g_vld = in_valid;
`endif

    wire [WIDTH-1:0] not_w;
    wire [WIDTH-1:0] nor_w;
    wire [WIDTH-1:0] or_w;
    wire [WIDTH-1:0] and_w;
    wire [WIDTH-1:0] nand_w;
    wire [WIDTH-1:0] xor_w;
    wire [WIDTH-1:0] xnor_w;

    // One primitive level per bit; no cross-bit logic.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        not  u_not  (not_w[i],  g_a[i]);
        nor  u_nor  (nor_w[i],  g_a[i], g_b[i]);
        or   u_or   (or_w[i],   g_a[i], g_b[i]);
        and  u_and  (and_w[i],  g_a[i], g_b[i]);
        nand u_nand (nand_w[i], g_a[i], g_b[i]);
        xor  u_xor  (xor_w[i],  g_a[i], g_b[i]);
        xnor u_xnor (xnor_w[i], g_a[i], g_b[i]);
    end

    logic [WIDTH-1:0] not_q,  not_d;
    logic [WIDTH-1:0] nor_q,  nor_d;
    logic [WIDTH-1:0] or_q,   or_d;
    logic [WIDTH-1:0] and_q,  and_d;
    logic [WIDTH-1:0] nand_q, nand_d;
    logic [WIDTH-1:0] xor_q,  xor_d;
    logic [WIDTH-1:0] xnor_q, xnor_d;
    logic             vld_out_q;

    // Capture on a qualified vector, otherwise hold.
    always_comb begin
        not_d  = not_q;
        nor_d  = nor_q;
        or_d   = or_q;
        and_d  = and_q;
        nand_d = nand_q;
        xor_d  = xor_q;
        xnor_d = xnor_q;
        if (g_vld) begin
            not_d  = not_w;
            nor_d  = nor_w;
            or_d   = or_w;
            and_d  = and_w;
            nand_d = nand_w;
            xor_d  = xor_w;
            xnor_d = xnor_w;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            not_q     <= '0;
            nor_q     <= '0;
            or_q      <= '0;
            and_q     <= '0;
            nand_q    <= '0;
            xor_q     <= '0;
            xnor_q    <= '0;
            vld_out_q <= 1'b0;
        end else begin
            not_q     <= not_d;
            nor_q     <= nor_d;
            or_q      <= or_d;
            and_q     <= and_d;
            nand_q    <= nand_d;
            xor_q     <= xor_d;
            xnor_q    <= xnor_d;
            vld_out_q <= g_vld;
        end
    end

    assign not_g     = not_q;
    assign nor_g     = nor_q;
    assign or_g      = or_q;
    assign and_g     = and_q;
    assign nand_g    = nand_q;
    assign xor_g     = xor_q;
    assign xnor_g    = xnor_q;
    assign out_valid = vld_out_q;

endmodule

// File: tb/tb_rtl_str_unit.sv
// Bench for rtl_str_unit (WIDTH=8): per-cycle reference model plus hand-computed known answers.
// Define RTL_STR_IN_REG_EN for both files to exercise the 2-cycle build.
module tb_rtl_str_unit;

    localparam int unsigned W = 8;
`ifdef RTL_STR_IN_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam int N = 256;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] a, b;
    logic [W-1:0] not_g, nor_g, or_g, and_g, nand_g, xor_g, xnor_g;
    logic         out_valid;

    rtl_str_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
        .not_g(not_g), .nor_g(nor_g), .or_g(or_g), .and_g(and_g),
        .nand_g(nand_g), .xor_g(xor_g), .xnor_g(xnor_g), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Input history and observed outputs, indexed by rising-edge number.
    logic         rst_h [N];
    logic         vld_h [N];
    logic [W-1:0] a_h   [N];
    logic [W-1:0] b_h   [N];
    logic [56:0]  obs   [N];
    int           cyc     = 0;
    bit           started = 1'b0;
    logic [56:0]  exp_s;

    task automatic chk(input string name, input logic [56:0] got, input logic [56:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got ov=%b res=%h, want ov=%b res=%h",
                     name, got[56], got[55:0], want[56], want[55:0]);
        end
    endtask

    // Packs {out_valid, not, nor, or, and, nand, xor, xnor} from the gate truth tables.
    function automatic logic [56:0] ref_res(input logic ov, input logic [W-1:0] x, input logic [W-1:0] y);
        return {ov, ~x, ~(x | y), x | y, x & y, ~(x & y), x ^ y, ~(x ^ y)};
    endfunction

    // A vector sampled at edge m shows after edge m+LAT-1 unless a reset hits any edge in between.
    always @(posedge clk) begin
        int  k, m;
        bit  ok;
        k        = cyc;
        rst_h[k] = rst;
        vld_h[k] = in_valid;
        a_h[k]   = a;
        b_h[k]   = b;
        cyc++;
        #1;
        obs[k] = {out_valid, not_g, nor_g, or_g, and_g, nand_g, xor_g, xnor_g};
        if (rst_h[k]) begin
            started = 1'b1;
            exp_s   = '0;
        end else if (started) begin
            m  = k - LAT + 1;
            ok = (m >= 0) && vld_h[m];
            for (int j = m; j <= k; j++) if (j >= 0 && rst_h[j]) ok = 1'b0;
            if (ok) exp_s = ref_res(1'b1, a_h[m], b_h[m]);
            else    exp_s = {1'b0, exp_s[55:0]};
        end
        if (started) chk($sformatf("model@%0d", k), obs[k], exp_s);
    end

    // Drive one cycle at the falling edge; returns the edge index that samples it.
    task automatic drive(input logic r, input logic v, input logic [W-1:0] x, input logic [W-1:0] y,
                         output int idx);
        @(negedge clk);
        rst = r; in_valid = v; a = x; b = y;
        idx = cyc;
    endtask

    initial begin
        int r0, r1, t00, t01, t10, t11, hd, bb1, bb2, col, d;
        rst = 1'b0; in_valid = 1'b0; a = '0; b = '0;

        drive(1'b1, 1'b1, 8'hFF, 8'hFF, r0);
        drive(1'b1, 1'b1, 8'hFF, 8'hFF, r1);
        drive(1'b0, 1'b0, 8'h00, 8'h00, d);
        drive(1'b0, 1'b1, 8'h00, 8'h00, t00);
        drive(1'b0, 1'b0, 8'h00, 8'h00, d);
        drive(1'b0, 1'b1, 8'h00, 8'hFF, t01);
        drive(1'b0, 1'b1, 8'hFF, 8'h00, t10);
        drive(1'b0, 1'b1, 8'hFF, 8'hFF, t11);
        drive(1'b0, 1'b0, 8'h00, 8'hFF, d);
        drive(1'b0, 1'b0, 8'hFF, 8'h00, d);
        drive(1'b0, 1'b0, 8'h5A, 8'hA5, hd);
        drive(1'b0, 1'b0, 8'h00, 8'h00, d);
        drive(1'b0, 1'b0, 8'h00, 8'h00, d);
        drive(1'b0, 1'b1, 8'hF0, 8'hCC, bb1);
        drive(1'b0, 1'b1, 8'h0F, 8'h33, bb2);
        drive(1'b0, 1'b0, 8'h00, 8'h00, d);
        drive(1'b0, 1'b0, 8'h00, 8'h00, d);
        drive(1'b1, 1'b1, 8'hAA, 8'h55, col);
        drive(1'b0, 1'b0, 8'h00, 8'h00, d);
        // In-flight vector followed by reset: dropped in the 2-cycle build.
        drive(1'b0, 1'b1, 8'h3C, 8'h96, d);
        drive(1'b1, 1'b0, 8'h00, 8'h00, d);
        for (int i = 0; i < 40; i++)
            drive(1'b0, 1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom), d);
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 8'h00, 8'h00, d);
        @(posedge clk); #2;

        // Known answers, hand-computed from the truth tables.
        chk("reset0", obs[r0], 57'h0);
        chk("reset1", obs[r1], 57'h0);
        chk("a0b0", obs[t00+LAT-1], {1'b1, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00, 8'hFF});
        chk("a0b1", obs[t01+LAT-1], {1'b1, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'h00});
        chk("a1b0", obs[t10+LAT-1], {1'b1, 8'h00, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'h00});
        chk("a1b1", obs[t11+LAT-1], {1'b1, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF});
        chk("hold", obs[hd+LAT-1],  {1'b0, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF});
        chk("lat_pre", {56'h0, obs[bb1+LAT-2][56]}, 57'h0);
        chk("bb1", obs[bb1+LAT-1], {1'b1, 8'h0F, 8'h03, 8'hFC, 8'hC0, 8'h3F, 8'h3C, 8'hC3});
        chk("bb2", obs[bb2+LAT-1], {1'b1, 8'hF0, 8'hC0, 8'h3F, 8'h03, 8'hFC, 8'h3C, 8'hC3});
        chk("rst_wins", obs[col], 57'h0);
        chk("rst_wins_next", obs[col+1], 57'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rtl_str_unit.md
# rtl_str_unit

Registered two-operand logic-gate bank: computes NOT, NOR, OR, AND, NAND, XOR and XNOR of two WIDTH-bit operands using per-bit gate primitive instances, and presents all seven results from output registers. It serves as the structural-modeling reference cell in the basic-logic library and as a known-answer source for gate-level bring-up benches. Module name: rtl_str_unit.

## Interface
- WIDTH, 1, bit width of each operand and each result; legal range 1..64.
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high; sampled on rising clk edge.
- in_valid  input  1  qualifies a and b for capture this cycle.
- a  input  WIDTH  operand A; also the sole source of not_g.
- b  input  WIDTH  operand B.
- not_g  output  WIDTH  registered ~a.
- nor_g  output  WIDTH  registered ~(a|b).
- or_g  output  WIDTH  registered a|b.
- and_g  output  WIDTH  registered a&b.
- nand_g  output  WIDTH  registered ~(a&b).
- xor_g  output  WIDTH  registered a^b.
- xnor_g  output  WIDTH  registered ~(a^b).
- out_valid  output  1  high for the cycle in which the result registers hold a freshly computed set of results.
- Port order: clk, rst, in_valid, a, b, not_g, nor_g, or_g, and_g, nand_g, xor_g, xnor_g, out_valid.

## Operation
- Per bit i, seven gate primitives (not, nor, or, and, nand, xor, xnor) are instantiated in a generate loop; no behavioral operators in the datapath.
- All seven results are bitwise; no cross-bit interaction; no arithmetic.
- Results are captured into output registers when in_valid=1; when in_valid=0, result registers hold their previous value.
- out_valid is the registered copy of in_valid, cleared by reset.
- Reset: all seven result outputs = 0, out_valid = 0. The all-zero reset state is not a legal gate result (for example, not_g and nor_g cannot both be 0 when a=b=0); benches must use out_valid to qualify results.
- If rst=1 and in_valid=1 in the same cycle, reset wins: outputs become 0 and the input vector is dropped.
- X/Z on a or b propagates per primitive semantics; no sanitizing.

## Timing
- Latency: 1 clk from in_valid and operand sampling to results and out_valid (2 clk with RTL_STR_IN_REG_EN).
- Throughput: one vector per clk; back-to-back in_valid is supported with no bubbles.
- Combinational path: input pins, then one primitive level, then the output flop. No output depends combinationally on any input.
- Reset deassertion: the first capture occurs on the first rising edge with rst=0 and in_valid=1.

## Configuration
- RTL_STR_IN_REG_EN defined:
  - Adds an input register stage on a, b and in_valid. This stage is also reset synchronously to 0.
  - Total latency becomes 2 clk.
  - out_valid follows the delayed in_valid.
- RTL_STR_IN_REG_EN undefined:
  - Gates are fed directly from the ports.
  - Latency is 1 clk.
- Function and reset values are identical in both builds.

## Test plan
- Reset: assert rst for 2 clk with in_valid=1, a=1, b=1 -> all outputs 0 and out_valid=0 throughout; no capture.
- a=0, b=0, in_valid=1 (WIDTH=1) -> next clk: not=1, nor=1, or=0, and=0, nand=1, xor=0, xnor=1, out_valid=1.
- a=0, b=1, then a=1, b=0 -> each gives nor=0, or=1, and=0, nand=1, xor=1, xnor=0. not_g is 1 for the first vector and 0 for the second.
- a=1, b=1 -> not=0, nor=0, or=1, and=1, nand=0, xor=0, xnor=1.
- Hold: after the a=1, b=1 result, drop in_valid and toggle a and b -> outputs remain at the a=1, b=1 values and out_valid=0.
- WIDTH=8, back-to-back vectors a=8'hF0, b=8'hCC then a=8'h0F, b=8'h33:
  - First result: and=8'hC0, or=8'hFC, xor=8'h3C, nand=8'h3F, nor=8'h03, xnor=8'hC3, not=8'h0F.
  - Second result follows 1 clk later.
  - Repeat with RTL_STR_IN_REG_EN defined and check latency = 2.
